// File: rtl/ccu_pkg.sv
// ccu_pkg: shared states, opcodes, microword field positions and decode helper for micro_seq.
package ccu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_SETTLE, S_DONE} state_e;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_BRZ   = 4'd9;
  localparam logic [3:0] OP_BRN   = 4'd10;
  localparam logic [3:0] OP_BRC   = 4'd11;
  localparam logic [3:0] OP_RSVD  = 4'd12;
  localparam logic [3:0] OP_JMP   = 4'd13;
  localparam logic [3:0] OP_NOP   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;
  localparam logic [3:0] DPU_IDLE = 4'hF;
  localparam int OP_MSB = 23, OP_LSB = 20;
  localparam int R_MSB = 19, R_LSB = 16;
  localparam int A_MSB = 15, A_LSB = 12;
  localparam int B_MSB = 11, B_LSB = 8;
  localparam int IMM_MSB = 7, IMM_LSB = 0;
  localparam logic [1:0] CC_N = 2'd3, CC_Z = 2'd2, CC_BRC = 2'd0;
  // condition-code bit tested by a conditional branch opcode
  function automatic logic [1:0] cc_bit(input logic [3:0] op);
    return op == OP_BRZ ? CC_Z : op == OP_BRN ? CC_N : CC_BRC;
  endfunction
endpackage

// File: rtl/micro_decode.sv
// micro_decode: splits a microword into DPU fields and resolves control-op branch outcome.
module micro_decode
  import ccu_pkg::*;
(
  input  logic [23:0] word,
  input  logic [3:0]  cc_q,
  output logic [3:0]  op,
  output logic [3:0]  r,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic [7:0]  imm,
  output logic        is_ctrl,
  output logic        is_halt,
  output logic        taken,
  output logic [7:0]  target
);
  assign op      = word[OP_MSB:OP_LSB];
  assign r       = word[R_MSB:R_LSB];
  assign a       = word[A_MSB:A_LSB];
  assign b       = word[B_MSB:B_LSB];
  assign imm     = word[IMM_MSB:IMM_LSB];
  assign is_ctrl = op > OP_LOAD;
  assign is_halt = op == OP_HALT;
  assign target  = imm;
  assign taken   = op == OP_JMP ||
                   ((op == OP_BRZ || op == OP_BRN || op == OP_BRC) && cc_q[cc_bit(op)]);
endmodule

// File: rtl/micro_seq.sv
// micro_seq: microprogram sequencer issuing DPU register/opcode selects from a synchronous program memory.
module micro_seq
  import ccu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  start_pc,
  input  logic        abort,
  output logic [7:0]  imem_addr,
  input  logic [23:0] imem_data,
  input  logic [3:0]  cc,
  output logic [3:0]  Abus,
  output logic [3:0]  Bbus,
  output logic [3:0]  Rbus,
  output logic [3:0]  n,
  output logic [7:0]  mData,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pc
);
  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d, addr_q, addr_d, mdata_q, mdata_d;
  logic [3:0]  cc_q, cc_d, a_q, a_d, b_q, b_d, r_q, r_d, n_q, n_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [3:0]  op, f_r, f_a, f_b;
  logic [7:0]  imm, target;
  logic        is_ctrl, is_halt, taken;

  micro_decode u_dec (
    .word(imem_data), .cc_q(cc_q), .op(op), .r(f_r), .a(f_a), .b(f_b), .imm(imm),
    .is_ctrl(is_ctrl), .is_halt(is_halt), .taken(taken), .target(target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    cc_d    = cc_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    n_d     = n_q;
    mdata_d = mdata_q;
    if (abort) begin
      state_d = S_IDLE;
      n_d     = DPU_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
          addr_d  = start_pc;
        end
        S_FETCH: state_d = S_ISSUE;
        S_ISSUE: if (is_halt) begin
          state_d = S_DONE;
          n_d     = DPU_IDLE;
        end else if (is_ctrl) begin
          state_d = S_FETCH;
          n_d     = DPU_IDLE;
          pc_d    = taken ? target : pc_q + 8'd1;
          addr_d  = pc_d;
        end else begin
          state_d = S_SETTLE;
          a_d     = f_a;
          b_d     = f_b;
          r_d     = f_r;
          n_d     = op;
          mdata_d = imm;
        end
        // the DPU op is presented only during SETTLE; flags come from ALU ops only
        S_SETTLE: begin
          state_d = S_FETCH;
          cc_d    = n_q[3] ? cc_q : cc;
          pc_d    = pc_q + 8'd1;
          addr_d  = pc_d;
          n_d     = DPU_IDLE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      cc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      n_q     <= DPU_IDLE;
      mdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cc_q    <= cc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      n_q     <= n_d;
      mdata_q <= mdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign imem_addr = addr_q;
  assign Abus      = a_q;
  assign Bbus      = b_q;
  assign Rbus      = r_q;
  assign n         = n_q;
  assign mData     = mdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pc        = pc_q;
endmodule

// File: tb/tb_micro_seq.sv
// tb_micro_seq: directed scenarios plus randomized programs checked each cycle against an instruction-level model.
module tb_micro_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0]  start_pc = '0, imem_addr, mData, pc;
  logic [23:0] imem_data;
  logic [3:0]  cc = '0, Abus, Bbus, Rbus, n;
  logic        busy, done;
  logic [23:0] mem [256];
  int          n_cmp = 0, n_err = 0;
  bit          chk_en = 1'b0;

  micro_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .abort(abort),
    .imem_addr(imem_addr), .imem_data(imem_data), .cc(cc), .Abus(Abus), .Bbus(Bbus),
    .Rbus(Rbus), .n(n), .mData(mData), .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= mem[imem_addr];

  // model: cyc counts cycles within the current instruction (0 = not running)
  int         cyc = 0;
  logic [7:0] m_pc, e_addr, e_md;
  logic [3:0] m_ccq, e_a, e_b, e_r, e_n;
  logic       e_busy, e_done;
  always @(posedge clk) begin
    logic [23:0] w;
    logic [3:0]  op;
    logic        tk;
    if (!rst_n) begin
      chk_en = 1'b1; cyc = 0; m_pc = 0; m_ccq = 0; e_addr = 0;
      e_a = 0; e_b = 0; e_r = 0; e_n = 4'hF; e_md = 0; e_busy = 0; e_done = 0;
    end else if (abort) begin
      cyc = 0; e_n = 4'hF; e_busy = 0; e_done = 0;
    end else if (cyc == 0) begin
      if (start) begin cyc = 1; m_pc = start_pc; e_addr = start_pc; e_busy = 1; end
    end else if (cyc == 1) begin
      cyc = 2;
    end else if (cyc == 2) begin
      w = mem[m_pc]; op = w[23:20];
      if (op == 15) begin cyc = 4; e_done = 1; end
      else if (op >= 9) begin
        tk = (op == 9 && m_ccq[2]) || (op == 10 && m_ccq[3]) || (op == 11 && m_ccq[0]) || op == 13;
        m_pc = tk ? w[7:0] : m_pc + 8'd1; e_addr = m_pc; e_n = 4'hF; cyc = 1;
      end else begin
        e_r = w[19:16]; e_a = w[15:12]; e_b = w[11:8]; e_n = op; e_md = w[7:0]; cyc = 3;
      end
    end else if (cyc == 3) begin
      if (e_n < 8) m_ccq = cc;
      m_pc = m_pc + 8'd1; e_addr = m_pc; e_n = 4'hF; cyc = 1;
    end else begin
      cyc = 0; e_done = 0; e_busy = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("Abus", 32'(Abus), 32'(e_a));
    chk("Bbus", 32'(Bbus), 32'(e_b));
    chk("Rbus", 32'(Rbus), 32'(e_r));
    chk("n", 32'(n), 32'(e_n));
    chk("mData", 32'(mData), 32'(e_md));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
  end

  task automatic go(input logic [7:0] a);
    start = 1; start_pc = a;
    @(negedge clk);
    start = 0;
  endtask

  task automatic kill();
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 24'hE00000;
    mem[8'h10] = 24'h8900AA; mem[8'h11] = 24'hF00000;
    mem[8'h20] = 24'h012300; mem[8'h21] = 24'h900040;
    repeat (2) @(negedge clk);
    chk("rst_n", 32'(n), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1;
    @(negedge clk);
    go(8'h10);
    repeat (2) @(negedge clk);
    chk("load_n", 32'(n), 32'h8);
    chk("load_R", 32'(Rbus), 32'h9);
    chk("load_imm", 32'(mData), 32'hAA);
    repeat (3) @(negedge clk);
    chk("halt_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("halt_done_end", 32'(done), 32'h0);
    chk("halt_busy", 32'(busy), 32'h0);
    chk("halt_pc", 32'(pc), 32'h11);
    cc = 4'b0100;
    go(8'h20);
    repeat (5) @(negedge clk);
    chk("brz_taken", 32'(imem_addr), 32'h40);
    kill();
    cc = 4'b0000;
    go(8'h20);
    repeat (5) @(negedge clk);
    chk("brz_not_taken", 32'(imem_addr), 32'h22);
    kill();
    mem[8'hFF] = 24'hD00000;
    go(8'hFF);
    repeat (2) @(negedge clk);
    chk("jmp_wrap", 32'(imem_addr), 32'h00);
    kill();
    mem[8'hFF] = 24'hE00000;
    go(8'hFF);
    repeat (2) @(negedge clk);
    chk("nop_wrap", 32'(imem_addr), 32'h00);
    chk("nop_wrap_pc", 32'(pc), 32'h00);
    kill();
    go(8'h10);
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_n", 32'(n), 32'hF);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    go(8'h10);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst_mid_pc", 32'(pc), 32'h0);
    chk("rst_mid_R", 32'(Rbus), 32'h0);
    chk("rst_mid_n", 32'(n), 32'hF);
    go(8'h10);
    start = 1; start_pc = 8'h55;
    @(negedge clk);
    start = 0;
    chk("start_busy_pc", 32'(pc), 32'h10);
    repeat (5) @(negedge clk);
    chk("start_busy_end", 32'(busy), 32'h0);
    rst_n = 0;
    foreach (mem[i]) mem[i] = 24'($urandom);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4000; k++) begin
      start    = $urandom_range(0, 5) == 0;
      start_pc = 8'($urandom);
      abort    = $urandom_range(0, 80) == 0;
      rst_n    = $urandom_range(0, 300) != 0;
      cc       = 4'($urandom);
      @(negedge clk);
    end
    start = 0; abort = 0; rst_n = 1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
